sevseg_scanner: RTL and testbench

SEVSEG_SCANNER -- requirements
Module: sevseg_scanner

---
 rtl/sevseg_scanner.sv | 129 ++++++++++++
 tb/tb_sevseg_scanner.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scanner.sv
// Multiplexed seven-segment hex display scanner with a per-digit write buffer.
// Optional macro SEVSEG_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module sevseg_scanner #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef SEVSEG_BRIGHTNESS_EN
    input  logic [3:0]                brightness,
`endif
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_idx,
    input  logic [3:0]                wr_val,
    input  logic                      wr_blank,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         sel,
    output logic                      frame_tick
);

    localparam int                IDX_W    = $clog2(DIGITS);
    localparam int                PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic              INV      = (ACTIVE_LOW != 0);
    localparam logic [6:0]        SEG_OFF  = {7{INV}};
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{INV}};

    logic [PRE_W-1:0]  prescaler;
    logic [IDX_W-1:0]  idx;
    logic [4:0]        buffer [DIGITS];
    logic              slot_end;
    logic [4:0]        cur;
    logic [6:0]        seg_hi;
    logic              show;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] sel_next;

    assign slot_end = (prescaler == PRE_LAST);

    // frame_tick is raised on the same edge the index wraps, so it is high
    // for the single cycle that follows the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (slot_end) begin
                prescaler <= '0;
                if (idx == IDX_LAST) begin
                    idx        <= '0;
                    frame_tick <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                buffer[i] <= 5'h10;
            end
        end else if (wr_en && (32'(wr_idx) < DIGITS)) begin
            buffer[wr_idx] <= {wr_blank, wr_val};
        end
    end

`ifdef SEVSEG_BRIGHTNESS_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end
`endif

    // Decode in active-high form; polarity is applied when registering.
    always_comb begin
        cur    = buffer[idx];
        seg_hi = 7'h00;
        case (cur[3:0])
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            4'hF: seg_hi = 7'h71;
            default: seg_hi = 7'h00;
        endcase
`ifdef SEVSEG_BRIGHTNESS_EN
        show = !cur[4] && (pwm_cnt <= brightness);
`else
        show = !cur[4];
`endif
        seg_next = show ? seg_hi : 7'h00;
        sel_next = show ? (DIGITS'(1) << idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            sel <= SEL_OFF;
        end else begin
            seg <= seg_next ^ SEG_OFF;
            sel <= sel_next ^ SEL_OFF;
        end
    end

endmodule

// File: tb/tb_sevseg_scanner.sv
// Self-checking bench for sevseg_scanner: two scanner instances (4 and 3 digits,
// both polarities) plus a brightness instance when SEVSEG_BRIGHTNESS_EN is defined.
module tb_sevseg_scanner;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 4 digits, 4 clocks per slot, active-low.
    logic       a_rst_n = 1'b0, a_wr_en = 1'b0, a_wr_blank = 1'b0;
    logic [1:0] a_wr_idx = '0;
    logic [3:0] a_wr_val = '0;
    logic [6:0] a_seg;
    logic [3:0] a_sel;
    logic       a_tick;
    logic [4:0] a_buf [4];
    int         a_k;
    logic [6:0] a_exp_seg;
    logic [3:0] a_exp_sel;
    logic       a_exp_tick;

    // Instance B: 3 digits, 4 clocks per slot, active-high.
    logic       b_rst_n = 1'b0, b_wr_en = 1'b0, b_wr_blank = 1'b0;
    logic [1:0] b_wr_idx = '0;
    logic [3:0] b_wr_val = '0;
    logic [6:0] b_seg;
    logic [2:0] b_sel;
    logic       b_tick;
    logic [4:0] b_buf [3];
    int         b_k;
    logic [6:0] b_exp_seg;
    logic [2:0] b_exp_sel;
    logic       b_exp_tick;

    sevseg_scanner #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
`ifdef SEVSEG_BRIGHTNESS_EN
        .brightness(4'hF),
`endif
        .wr_en(a_wr_en), .wr_idx(a_wr_idx), .wr_val(a_wr_val), .wr_blank(a_wr_blank),
        .seg(a_seg), .sel(a_sel), .frame_tick(a_tick)
    );

    sevseg_scanner #(.DIGITS(3), .CLK_DIV(4), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
`ifdef SEVSEG_BRIGHTNESS_EN
        .brightness(4'hF),
`endif
        .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_val(b_wr_val), .wr_blank(b_wr_blank),
        .seg(b_seg), .sel(b_sel), .frame_tick(b_tick)
    );

`ifdef SEVSEG_BRIGHTNESS_EN
    // Instance C: 4 digits, 32 clocks per slot, active-low, PWM brightness.
    logic       c_rst_n = 1'b0, c_wr_en = 1'b0, c_wr_blank = 1'b0;
    logic [1:0] c_wr_idx = '0;
    logic [3:0] c_wr_val = '0;
    logic [3:0] c_bright = 4'hF;
    logic [6:0] c_seg;
    logic [3:0] c_sel;
    logic       c_tick;
    logic [4:0] c_buf [4];
    int         c_k;
    logic [6:0] c_exp_seg;
    logic [3:0] c_exp_sel;
    logic       c_exp_tick;

    sevseg_scanner #(.DIGITS(4), .CLK_DIV(32), .ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .brightness(c_bright),
        .wr_en(c_wr_en), .wr_idx(c_wr_idx), .wr_val(c_wr_val), .wr_blank(c_wr_blank),
        .seg(c_seg), .sel(c_sel), .frame_tick(c_tick)
    );

    task automatic reset_c();
        c_rst_n = 1'b0;
        c_wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) c_buf[i] = 5'h10;
        c_k = 0;
        c_rst_n = 1'b1;
    endtask

    // After edge k the outputs show the slot and PWM phase that held before edge k.
    task automatic step_c();
        int slot;
        int pwm;
        @(posedge clk);
        c_k++;
        slot = ((c_k - 1) / 32) % 4;
        pwm  = (c_k - 1) % 16;
        if (!c_buf[slot][4] && (pwm <= int'(c_bright))) begin
            c_exp_seg = ~HEX[c_buf[slot][3:0]];
            c_exp_sel = ~(4'b0001 << slot);
        end else begin
            c_exp_seg = 7'h7F;
            c_exp_sel = 4'hF;
        end
        c_exp_tick = (c_k % 128 == 0);
        if (c_wr_en) c_buf[c_wr_idx] = {c_wr_blank, c_wr_val};
        #1;
    endtask
`endif

    task automatic reset_a();
        a_rst_n = 1'b0;
        a_wr_en = 1'b0;
        a_wr_idx = '0;
        a_wr_val = '0;
        a_wr_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) a_buf[i] = 5'h10;
        a_k = 0;
        a_rst_n = 1'b1;
    endtask

    task automatic reset_b();
        b_rst_n = 1'b0;
        b_wr_en = 1'b0;
        b_wr_idx = '0;
        b_wr_val = '0;
        b_wr_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) b_buf[i] = 5'h10;
        b_k = 0;
        b_rst_n = 1'b1;
    endtask

    // Reference: slot = floor((k-1)/CLK_DIV) mod DIGITS, tick every DIGITS*CLK_DIV edges.
    task automatic step_a();
        int slot;
        @(posedge clk);
        a_k++;
        slot = ((a_k - 1) / 4) % 4;
        if (a_buf[slot][4]) begin
            a_exp_seg = 7'h7F;
            a_exp_sel = 4'hF;
        end else begin
            a_exp_seg = ~HEX[a_buf[slot][3:0]];
            a_exp_sel = ~(4'b0001 << slot);
        end
        a_exp_tick = (a_k % 16 == 0);
        if (a_wr_en) a_buf[a_wr_idx] = {a_wr_blank, a_wr_val};
        #1;
    endtask

    task automatic step_b();
        int slot;
        @(posedge clk);
        b_k++;
        slot = ((b_k - 1) / 4) % 3;
        if (b_buf[slot][4]) begin
            b_exp_seg = 7'h00;
            b_exp_sel = 3'b000;
        end else begin
            b_exp_seg = HEX[b_buf[slot][3:0]];
            b_exp_sel = 3'b001 << slot;
        end
        b_exp_tick = (b_k % 12 == 0);
        if (b_wr_en && (int'(b_wr_idx) < 3)) b_buf[b_wr_idx] = {b_wr_blank, b_wr_val};
        #1;
    endtask

    task automatic test_reset();
        reset_a();
        reset_b();
        repeat (10) step_a();
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_seg, a_sel, a_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async_a got %h/%h/%b expected 7f/f/0", a_seg, a_sel, a_tick);
        end
        checks++;
        if ({b_seg, b_sel, b_tick} !== {7'h00, 3'b000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async_b got %h/%h/%b expected 00/0/0", b_seg, b_sel, b_tick);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_seg, a_sel, a_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_held_a got %h/%h/%b expected 7f/f/0", a_seg, a_sel, a_tick);
        end
        // Abort just before the edge that would have produced a frame tick.
        reset_a();
        repeat (15) step_a();
        a_rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({a_seg, a_sel, a_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_midscan got %h/%h/%b expected 7f/f/0", a_seg, a_sel, a_tick);
        end
        reset_a();
        step_a();
        checks++;
        if ({a_seg, a_sel, a_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_first_slot got %h/%h/%b expected 7f/f/0", a_seg, a_sel, a_tick);
        end
    endtask

    task automatic test_scan();
        logic [3:0] vals [4];
        logic [6:0] cseg [4];
        logic [3:0] csel [4];
        int slot;
        vals = '{4'h8, 4'h1, 4'hA, 4'hF};
        cseg = '{7'h00, 7'h79, 7'h08, 7'h0E};
        csel = '{4'hE, 4'hD, 4'hB, 4'h7};
        reset_a();
        for (int i = 0; i < 4; i++) begin
            a_wr_en = 1'b1;
            a_wr_idx = 2'(i);
            a_wr_val = vals[i];
            a_wr_blank = 1'b0;
            step_a();
            checks++;
            if ({a_seg, a_sel, a_tick} !== {a_exp_seg, a_exp_sel, a_exp_tick}) begin
                errors++;
                $display("[TB] FAIL scan_load k=%0d got %h/%h/%b expected %h/%h/%b",
                         a_k, a_seg, a_sel, a_tick, a_exp_seg, a_exp_sel, a_exp_tick);
            end
        end
        a_wr_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step_a();
            slot = ((a_k - 1) / 4) % 4;
            checks++;
            if ({a_seg, a_sel} !== {cseg[slot], csel[slot]}) begin
                errors++;
                $display("[TB] FAIL scan_pattern k=%0d got %h/%h expected %h/%h",
                         a_k, a_seg, a_sel, cseg[slot], csel[slot]);
            end
        end
    endtask

    task automatic test_frame_tick();
        int ticks = 0;
        reset_a();
        for (int i = 0; i < 64; i++) begin
            step_a();
            if (a_tick === 1'b1) ticks++;
            checks++;
            if (a_tick !== a_exp_tick) begin
                errors++;
                $display("[TB] FAIL frame_tick k=%0d got %b expected %b", a_k, a_tick, a_exp_tick);
            end
        end
        checks++;
        if (ticks != 4) begin
            errors++;
            $display("[TB] FAIL frame_tick_count got %0d expected 4", ticks);
        end
    endtask

    task automatic test_random_a();
        reset_a();
        for (int i = 0; i < 200; i++) begin
            a_wr_en = ($urandom_range(0, 1) == 1);
            a_wr_idx = 2'($urandom_range(0, 3));
            a_wr_val = 4'($urandom_range(0, 15));
            a_wr_blank = ($urandom_range(0, 3) == 0);
            step_a();
            checks++;
            if ({a_seg, a_sel, a_tick} !== {a_exp_seg, a_exp_sel, a_exp_tick}) begin
                errors++;
                $display("[TB] FAIL random_a k=%0d got %h/%h/%b expected %h/%h/%b",
                         a_k, a_seg, a_sel, a_tick, a_exp_seg, a_exp_sel, a_exp_tick);
            end
        end
        a_wr_en = 1'b0;
    endtask

    task automatic test_index_wrap_b();
        reset_b();
        for (int i = 0; i < 3; i++) begin
            b_wr_en = 1'b1;
            b_wr_idx = 2'(i);
            b_wr_val = 4'(i + 1);
            b_wr_blank = 1'b0;
            step_b();
        end
        b_wr_idx = 2'd3;
        b_wr_val = 4'h5;
        for (int i = 0; i < 36; i++) begin
            step_b();
            checks++;
            if ({b_seg, b_sel, b_tick} !== {b_exp_seg, b_exp_sel, b_exp_tick}) begin
                errors++;
                $display("[TB] FAIL wrap_b k=%0d got %h/%h/%b expected %h/%h/%b",
                         b_k, b_seg, b_sel, b_tick, b_exp_seg, b_exp_sel, b_exp_tick);
            end
            checks++;
            if (b_seg === 7'h6D) begin
                errors++;
                $display("[TB] FAIL bad_write_shown k=%0d got %h expected not 6d", b_k, b_seg);
            end
        end
        for (int i = 0; i < 150; i++) begin
            b_wr_en = ($urandom_range(0, 1) == 1);
            b_wr_idx = 2'($urandom_range(0, 3));
            b_wr_val = 4'($urandom_range(0, 15));
            b_wr_blank = ($urandom_range(0, 3) == 0);
            step_b();
            checks++;
            if ({b_seg, b_sel, b_tick} !== {b_exp_seg, b_exp_sel, b_exp_tick}) begin
                errors++;
                $display("[TB] FAIL random_b k=%0d got %h/%h/%b expected %h/%h/%b",
                         b_k, b_seg, b_sel, b_tick, b_exp_seg, b_exp_sel, b_exp_tick);
            end
        end
        b_wr_en = 1'b0;
    endtask

    task automatic test_blank_live();
        logic [4:0] init [4];
        int slot;
        init = '{5'h08, 5'h01, 5'h17, 5'h0F};
        reset_a();
        for (int i = 0; i < 4; i++) begin
            a_wr_en = 1'b1;
            a_wr_idx = 2'(i);
            {a_wr_blank, a_wr_val} = init[i];
            step_a();
        end
        a_wr_en = 1'b0;
        for (int i = 0; i < 28; i++) begin
            step_a();
            slot = ((a_k - 1) / 4) % 4;
            checks++;
            if ({a_seg, a_sel, a_tick} !== {a_exp_seg, a_exp_sel, a_exp_tick}) begin
                errors++;
                $display("[TB] FAIL blank_model k=%0d got %h/%h/%b expected %h/%h/%b",
                         a_k, a_seg, a_sel, a_tick, a_exp_seg, a_exp_sel, a_exp_tick);
            end
            if (slot == 2) begin
                checks++;
                if ({a_seg, a_sel} !== {7'h7F, 4'hF}) begin
                    errors++;
                    $display("[TB] FAIL blank_slot k=%0d got %h/%h expected 7f/f", a_k, a_seg, a_sel);
                end
            end
        end
        for (int i = 0; i < 16 && (a_k % 16 != 1); i++) step_a();
        a_wr_en = 1'b1;
        a_wr_idx = 2'd0;
        a_wr_val = 4'h3;
        a_wr_blank = 1'b0;
        step_a();
        a_wr_en = 1'b0;
        checks++;
        if ({a_seg, a_sel} !== {7'h00, 4'hE}) begin
            errors++;
            $display("[TB] FAIL live_write_early got %h/%h expected 00/e", a_seg, a_sel);
        end
        step_a();
        checks++;
        if ({a_seg, a_sel} !== {7'h30, 4'hE}) begin
            errors++;
            $display("[TB] FAIL live_write got %h/%h expected 30/e", a_seg, a_sel);
        end
    endtask

`ifdef SEVSEG_BRIGHTNESS_EN
    task automatic test_brightness();
        int active;
        logic [3:0] levels [2];
        int expect_cnt [2];
        levels = '{4'd3, 4'd15};
        expect_cnt = '{8, 32};
        reset_c();
        for (int i = 0; i < 4; i++) begin
            c_wr_en = 1'b1;
            c_wr_idx = 2'(i);
            c_wr_val = 4'h8;
            c_wr_blank = 1'b0;
            step_c();
        end
        c_wr_en = 1'b0;
        for (int l = 0; l < 2; l++) begin
            c_bright = levels[l];
            for (int i = 0; i < 32 && (c_k % 32 != 0); i++) step_c();
            active = 0;
            for (int i = 0; i < 32; i++) begin
                step_c();
                if (c_sel !== 4'hF) active++;
                checks++;
                if ({c_seg, c_sel, c_tick} !== {c_exp_seg, c_exp_sel, c_exp_tick}) begin
                    errors++;
                    $display("[TB] FAIL pwm_model k=%0d got %h/%h/%b expected %h/%h/%b",
                             c_k, c_seg, c_sel, c_tick, c_exp_seg, c_exp_sel, c_exp_tick);
                end
            end
            checks++;
            if (active != expect_cnt[l]) begin
                errors++;
                $display("[TB] FAIL pwm_duty brightness=%0d got %0d expected %0d",
                         levels[l], active, expect_cnt[l]);
            end
        end
        for (int i = 0; i < 96; i++) begin
            c_bright = 4'($urandom_range(0, 15));
            step_c();
            checks++;
            if ({c_seg, c_sel, c_tick} !== {c_exp_seg, c_exp_sel, c_exp_tick}) begin
                errors++;
                $display("[TB] FAIL pwm_random k=%0d got %h/%h/%b expected %h/%h/%b",
                         c_k, c_seg, c_sel, c_tick, c_exp_seg, c_exp_sel, c_exp_tick);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_frame_tick();
        test_random_a();
        test_index_wrap_b();
        test_blank_live();
`ifdef SEVSEG_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
